// File: rtl/ixu_decode.sv
// RV32I OP/OP-IMM decode and issue stage with forwarding detection and an illegal-word counter.
// Optional IXU_DECODE_SKID_EN selects a 2-entry skid buffer with registered in_ready_o; default is a single output register.
module ixu_decode #(
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [31:0]          in_instr_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [3:0]           op_o,
  output logic [11:0]          imm_o,
  output logic                 is_imm_type_o,
  output logic                 is_nop_o,
  output logic [4:0]           rs1_addr_o,
  output logic [4:0]           rs2_addr_o,
  output logic [4:0]           rd_addr_o,
  output logic                 is_rs1_fwd_o,
  output logic                 is_rs2_fwd_o,
  output logic                 illegal_o,
  output logic [ILL_CNT_W-1:0] ill_cnt_o
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  typedef struct packed {
    logic [3:0]  op;
    logic [11:0] imm;
    logic        is_imm_type;
    logic        is_nop;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rs1_fwd;
    logic        rs2_fwd;
    logic        illegal;
  } bundle_t;

  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic [6:0]           funct7;
  logic                 dec_legal;
  logic                 dec_is_imm;
  logic [3:0]           dec_op;
  bundle_t              dec;
  bundle_t              head_q;
  logic [4:0]           last_rd_q;
  logic                 last_rd_vld_q;
  logic [ILL_CNT_W-1:0] ill_cnt_q;
  logic                 accept;

  assign opcode = in_instr_i[6:0];
  assign funct3 = in_instr_i[14:12];
  assign funct7 = in_instr_i[31:25];

  always_comb begin
    dec_legal  = 1'b0;
    dec_is_imm = 1'b0;
    dec_op     = OP_ADD;
    case (opcode)
      OPC_OP: begin
        dec_legal = 1'b1;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  dec_op = OP_ADD;
            3'b001:  dec_op = OP_SLL;
            3'b010:  dec_op = OP_SLT;
            3'b011:  dec_op = OP_SLTU;
            3'b100:  dec_op = OP_XOR;
            3'b101:  dec_op = OP_SRL;
            3'b110:  dec_op = OP_OR;
            default: dec_op = OP_AND;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec_op = OP_SUB;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          dec_op = OP_SRA;
        end else begin
          dec_legal = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        dec_legal  = 1'b1;
        dec_is_imm = 1'b1;
        case (funct3)
          3'b000:  dec_op = OP_ADD;
          3'b010:  dec_op = OP_SLT;
          3'b011:  dec_op = OP_SLTU;
          3'b100:  dec_op = OP_XOR;
          3'b110:  dec_op = OP_OR;
          3'b111:  dec_op = OP_AND;
          3'b001: begin
            dec_op    = OP_SLL;
            dec_legal = (funct7 == 7'b0000000);
          end
          default: begin
            // funct3 101: shift kind is carried in the upper immediate bits
            if (funct7 == 7'b0000000) begin
              dec_op = OP_SRL;
            end else if (funct7 == 7'b0100000) begin
              dec_op = OP_SRA;
            end else begin
              dec_legal = 1'b0;
            end
          end
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    dec = '0;
    if (dec_legal) begin
      dec.op          = dec_op;
      dec.is_imm_type = dec_is_imm;
      dec.imm         = dec_is_imm ? in_instr_i[31:20] : 12'd0;
      dec.rs1         = in_instr_i[19:15];
      dec.rs2         = dec_is_imm ? 5'd0 : in_instr_i[24:20];
      dec.rd          = in_instr_i[11:7];
      dec.is_nop      = (in_instr_i[11:7] == 5'd0);
      // rs2 is forced to 0 for OP-IMM, so the rs2 compare can never hit there
      dec.rs1_fwd     = last_rd_vld_q && (dec.rs1 != 5'd0) && (dec.rs1 == last_rd_q);
      dec.rs2_fwd     = last_rd_vld_q && (dec.rs2 != 5'd0) && (dec.rs2 == last_rd_q);
    end else begin
      dec.is_nop  = 1'b1;
      dec.illegal = 1'b1;
    end
  end

  assign accept = in_valid_i && in_ready_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_rd_q     <= 5'd0;
      last_rd_vld_q <= 1'b0;
      ill_cnt_q     <= '0;
    end else if (flush_i) begin
      last_rd_vld_q <= 1'b0;
    end else if (accept) begin
      last_rd_q     <= dec.rd;
      last_rd_vld_q <= !dec.is_nop;
      if (dec.illegal && (ill_cnt_q != {ILL_CNT_W{1'b1}})) begin
        ill_cnt_q <= ill_cnt_q + 1'b1;
      end
    end
  end

`ifdef IXU_DECODE_SKID_EN
  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_e;

  state_e  state_q;
  bundle_t skid_q;
  logic    in_ready_q;
  logic    consume;

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = (state_q != S_EMPTY);
  assign consume     = out_valid_o && out_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else if (flush_i) begin
      state_q    <= S_EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            head_q  <= dec;
            state_q <= S_ONE;
          end
        end
        S_ONE: begin
          if (accept && consume) begin
            head_q <= dec;
          end else if (accept) begin
            skid_q     <= dec;
            state_q    <= S_TWO;
            in_ready_q <= 1'b0;
          end else if (consume) begin
            state_q <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (consume) begin
            head_q     <= skid_q;
            state_q    <= S_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= S_EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end
`else
  logic valid_q;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      head_q  <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      head_q  <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      head_q  <= dec;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end
`endif

  assign op_o          = head_q.op;
  assign imm_o         = head_q.imm;
  assign is_imm_type_o = head_q.is_imm_type;
  assign is_nop_o      = head_q.is_nop;
  assign rs1_addr_o    = head_q.rs1;
  assign rs2_addr_o    = head_q.rs2;
  assign rd_addr_o     = head_q.rd;
  assign is_rs1_fwd_o  = head_q.rs1_fwd;
  assign is_rs2_fwd_o  = head_q.rs2_fwd;
  assign illegal_o     = head_q.illegal;
  assign ill_cnt_o     = ill_cnt_q;

endmodule

// File: doc/ixu_decode.md
# ixu_decode

Integer-unit decode and issue stage, directly upstream of the integer execute stage. Accepts 32-bit RV32I OP and OP-IMM instructions over a valid/ready handshake. Produces the execute stage's control bundle: `op`, `imm`, `is_imm_type`, `is_nop`, and the `is_rs1_fwd`/`is_rs2_fwd` selects, from a registered output buffer. Also tracks the previous instruction's destination register for forwarding detection and counts illegal instructions.

## Interface
- `ILL_CNT_W`, 8: width of the saturating illegal-instruction counter.
- `clk` input 1: clock; all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous; empties buffer, clears forwarding history.
- `in_valid` input 1: `in_instr` is valid.
- `in_ready` output 1: stage can accept an instruction this cycle.
- `in_instr` input 32: raw instruction word.
- `out_valid` output 1: output bundle valid.
- `out_ready` input 1: execute stage consumes the bundle.
- `op` output 4: ALU op. ADD=0, SUB=1, XOR=2, OR=3, AND=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9.
- `imm` output 12: `instr[31:20]` for OP-IMM; 0 otherwise.
- `is_imm_type` output 1: OP-IMM instruction.
- `is_nop` output 1: rd==0 or illegal.
- `rs1_addr`, `rs2_addr`, `rd_addr` output 5 each: register indices. `rs2_addr` is 0 for OP-IMM.
- `is_rs1_fwd`, `is_rs2_fwd` output 1 each: operand equals rd of the immediately preceding accepted instruction.
- `illegal` output 1: bundle came from an undecodable word.
- `ill_cnt` output `ILL_CNT_W`: saturating count of accepted illegal words.

## Operation
- Accept occurs when `in_valid && in_ready`. Decode is combinational on `in_instr`; the result is written into the buffer on accept.
- Opcode `0110011` (OP), by funct7/funct3:
  - funct7 `0000000`: funct3 000→ADD, 100→XOR, 110→OR, 111→AND, 001→SLL, 101→SRL, 010→SLT, 011→SLTU.
  - funct7 `0100000`: funct3 000→SUB, 101→SRA.
  - Any other combination is illegal.
- Opcode `0010011` (OP-IMM), by funct3:
  - 000→ADD, 100→XOR, 110→OR, 111→AND, 010→SLT, 011→SLTU.
  - 001→SLL requires `instr[31:25]==0`.
  - 101→SRL when `instr[31:25]==0`, SRA when it is `0100000`.
  - Any other value is illegal.
- Any other opcode is illegal.
- Illegal bundle: `op=0`, `imm=0`, `is_imm_type=0`, `is_nop=1`, `illegal=1`, fwd flags 0.
- Forwarding history (`last_rd`, `last_rd_vld`):
  - Updated on every accept with the new rd.
  - `last_rd_vld` is set to `!is_nop`.
  - `is_rsN_fwd = last_rd_vld && rsN_addr!=0 && rsN_addr==last_rd`, evaluated against history before the update.
  - OP-IMM never sets `is_rs2_fwd`.
- `ill_cnt` increments on each accepted illegal word and saturates at all-ones.
- `flush`:
  - Clears buffer entries and `last_rd_vld`.
  - Ignores any same-cycle accept.
  - Does not clear `ill_cnt`.

## Timing
- Reset values: `out_valid=0`, all bundle outputs 0, `ill_cnt=0`, `last_rd_vld=0`. `in_ready=1` from the first cycle after reset release.
- Latency: an instruction accepted in cycle N is presented with `out_valid=1` in cycle N+1.
- Bundle outputs are registered. They are held stable while `out_valid && !out_ready`.
- Order is preserved; no instruction is dropped or duplicated.
- Simultaneous accept and consume with a single entry occupied: the new entry replaces it, and `out_valid` stays 1.
- Reset asserted mid-operation: the buffer is emptied immediately (asynchronously) and history is lost.

## Configuration
- `IXU_DECODE_SKID_EN` defined:
  - 2-entry skid buffer with states EMPTY, ONE, TWO.
  - `in_ready` is a register: 1 in EMPTY and ONE, 0 in TWO. No combinational path from `out_ready` to `in_ready`.
  - Transitions:
    - EMPTY→ONE on accept.
    - ONE→TWO on accept without consume.
    - ONE→EMPTY on consume without accept.
    - TWO→ONE on consume; no accept is possible in TWO.
  - Full throughput is sustained with `out_ready` toggling.
- Undefined:
  - Single output register.
  - `in_ready = !out_valid || out_ready` (combinational).
  - Same one-cycle latency.

## Test plan
- `0x002081B3` (add x3,x1,x2), then `0x40308233` (sub x4,x1,x3) -> first bundle `op=0`, fwd 0/0; second bundle `op=1`, `rd_addr=4`, `is_rs2_fwd=1`, `is_rs1_fwd=0`.
- `0xFFF10093` (addi x1,x2,-1) -> `op=0`, `is_imm_type=1`, `imm=0xFFF`, `rs2_addr=0`. Then `0x4050D113` (srai x2,x1,5) -> `op=7`, `imm=0x405`, `is_rs1_fwd=1`.
- `0x00000013` (nop) followed by `0x00000033` -> both `is_nop=1`; the second has no fwd flags (rd 0 never forwards).
- 300 words `0xFFFFFFFF` -> every bundle has `illegal=1` and `is_nop=1`; `ill_cnt` ends at 255.
- `out_ready` held low 3 cycles while `in_valid` stays high:
  - Skid build: exactly 2 accepts, then `in_ready=0`.
  - Non-skid build: exactly 1 accept.
  - In both builds, the bundle is stable while stalled and all words drain in order once `out_ready=1`.
- `flush` coincident with an accept of `0x002081B3`:
  - `out_valid=0` next cycle.
  - Next accepted `0x00108133` shows `is_rs1_fwd=0`.
